ps2_rx_fifo: RTL and testbench
==============================

Name: ps2_rx_fifo

Overview:
Parametrised PS/2 keyboard receiver, successor to the single-byte receiver.
- Synchronises ps2_clk and ps2_data, deserialises 11-bit frames and fully validates them (start, odd parity, stop).
- Recovers stalled frames with a bit timeout and folds E0/F0 prefixes into key events.
- Buffers events in a show-ahead FIFO read with a valid/ready handshake.
- Sits between the PS/2 pins and the console/keymap logic.

Parameters:
FIFO_DEPTH, 8, event entries buffered; power of two, 2..64
SYNC_STAGES, 3, synchroniser flops on ps2_clk and ps2_data; minimum 3
TIMEOUT_CYCLES, 50000, clk cycles without a falling ps2_clk edge before a partial frame is aborted

Ports:
clk  input  1  system clock
resetn  input  1  synchronous active-low reset
ps2_clk  input  1  raw PS/2 clock, asynchronous
ps2_data  input  1  raw PS/2 data, asynchronous
rd_data  output  10  head event {ext, brk, code[7:0]}
rd_valid  output  1  FIFO not empty
rd_ready  input  1  consumer pop; a pop occurs when rd_valid && rd_ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held
frame_err  output  1  one-cycle pulse: bad start, parity or stop, or timeout abort
overflow  output  1  sticky; set when an event is dropped on a full FIFO
clr_overflow  input  1  clears overflow; if a drop occurs in the same cycle, set wins

Behaviour:
- Reset is synchronous, active-low, on clk. It drives all outputs to 0, empties the FIFO, sets both synchronisers to all-1 (bus idle), and clears bit_cnt, timeout counter, ext_pend and brk_pend.
- Edge detect: a fall is registered when sync_clk[SYNC_STAGES-1]==1 and sync_clk[SYNC_STAGES-2]==0. ps2_data is sampled from sync_data[SYNC_STAGES-2] in the same cycle.
- Receive FSM:
  - IDLE: a fall with data=0 stores the start bit and moves to DATA. A fall with data=1 in IDLE is ignored (no error).
  - DATA: 8 falls shift data in LSB first.
  - PARITY: 1 fall.
  - STOP: on the stop fall, the frame is evaluated and the FSM returns to IDLE.
- Frame is valid iff start==0, stop==1, and XOR(data, parity)==1.
- Invalid frame: pulse frame_err in the cycle after the stop fall, discard the byte, clear ext_pend and brk_pend.
- Valid byte handling:
  - 8'hE0: set ext_pend, no push.
  - 8'hF0: set brk_pend, no push.
  - Any other byte: push {ext_pend, brk_pend, byte`, then clear both pending flags.
- Push timing: the push occurs in the cycle after the stop fall. rd_valid/rd_data reflect the new entry one cycle after the push, so an empty FIFO has 2 clk latency from stop fall to rd_valid.
- Timeout: the counter resets on every fall and counts only while the FSM is not IDLE. Reaching TIMEOUT_CYCLES-1 forces IDLE, pulses frame_err once, and clears the pending flags.
- FIFO: registered show-ahead, so rd_data is the head entry whenever rd_valid=1 and is don't-care when empty.
  - Push and pop in the same cycle: fifo_count unchanged, including when full.
  - Push while full with no pop: event dropped, overflow set, contents unchanged.
  - Pop while empty: ignored.
  - Read and write pointers wrap modulo FIFO_DEPTH; fifo_count ranges 0..FIFO_DEPTH.
- Reset asserted mid-frame: the partial frame is lost and no error is flagged.

Decomposition:
- Package ps2_pkg:
  - PS2_EXT_PREFIX=8'hE0, PS2_BRK_PREFIX=8'hF0
  - PS2_EVT_W=10; field indices EVT_EXT=9, EVT_BRK=8, EVT_CODE=7:0
  - receive FSM state enum {IDLE, DATA, PARITY, STOP}
- Sub-module ps2_event_fifo: generic synchronous show-ahead FIFO with WIDTH and DEPTH parameters, push/pop/full/empty/count. The top instantiates it with WIDTH=PS2_EVT_W.

Test Plan:
- Make code 0x1C (parity 0), rd_ready=0 → rd_valid=1 two clk after stop fall, rd_data=10'h01C, fifo_count=1, frame_err stays 0.
- Frames E0, F0, 75 (parity 0,1,0) → exactly one entry, rd_data=10'h375. A following 0x1C → 10'h01C, confirming the flags cleared.
- 0x1C sent with parity bit 1 → frame_err pulses one cycle, no push. Then F0 bad-stop followed by valid 0x1C → entry 10'h01C (brk flag cleared by the error).
- 4 bits of a frame, then ps2_clk held high with TIMEOUT_CYCLES=100 → frame_err pulse about 100 clk after the last fall. A fresh 0x1C frame is then received correctly.
- FIFO_DEPTH=4, rd_ready=0, 5 valid make codes 0x16, 0x1E, 0x26, 0x25, 0x2E → fifo_count=4, overflow=1, pops return 0x16, 0x1E, 0x26, 0x25. clr_overflow → overflow=0.
- FIFO full with rd_ready=1 held while a frame completes → push and pop in the same cycle, count stays 4, overflow stays 0. Then resetn=0 for 1 clk mid-frame → rd_valid=0, fifo_count=0, no frame_err.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants, event layout and receive FSM states for the PS/2 receiver
package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  localparam int PS2_EVT_W   = 10;
  localparam int EVT_EXT     = 9;
  localparam int EVT_BRK     = 8;
  localparam int EVT_CODE_HI = 7;
  localparam int EVT_CODE_LO = 0;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

endpackage

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - synchronous show-ahead FIFO; head entry visible whenever not empty
module ps2_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  // A pop frees the slot a full-FIFO push lands in, so both proceed together.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 keyboard receiver folding E0/F0 prefixes into buffered key events
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [PS2_EVT_W-1:0]          rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_clk_q, sync_data_q;
  rx_state_e              state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   start_q, start_d;
  logic                   parity_q, parity_d;
  logic [TW-1:0]          tmo_q, tmo_d;
  logic                   ext_pend_q, ext_pend_d;
  logic                   brk_pend_q, brk_pend_d;
  logic                   push_q, push_d;
  logic [PS2_EVT_W-1:0]   push_data_q, push_data_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic                   fall, data_bit, tmo_hit, frame_ok;
  logic                   fifo_full, fifo_empty;

  assign fall     = sync_clk_q[SYNC_STAGES-1] && !sync_clk_q[SYNC_STAGES-2];
  assign data_bit = sync_data_q[SYNC_STAGES-2];
  assign tmo_hit  = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign frame_ok = !start_q && data_bit && (^{shift_q, parity_q});

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    start_d     = start_q;
    parity_d    = parity_q;
    ext_pend_d  = ext_pend_q;
    brk_pend_d  = brk_pend_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    frame_err_d = 1'b0;
    tmo_d       = (state_q == IDLE) ? '0 : tmo_q + 1'b1;

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!data_bit) begin
            start_d   = data_bit;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end
        DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          parity_d = data_bit;
          state_d  = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!frame_ok) begin
            frame_err_d = 1'b1;
            ext_pend_d  = 1'b0;
            brk_pend_d  = 1'b0;
          end else if (shift_q == PS2_EXT_PREFIX) begin
            ext_pend_d = 1'b1;
          end else if (shift_q == PS2_BRK_PREFIX) begin
            brk_pend_d = 1'b1;
          end else begin
            push_d                               = 1'b1;
            push_data_d[EVT_EXT]                 = ext_pend_q;
            push_data_d[EVT_BRK]                 = brk_pend_q;
            push_data_d[EVT_CODE_HI:EVT_CODE_LO] = shift_q;
            ext_pend_d                           = 1'b0;
            brk_pend_d                           = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_hit) begin
      // A stalled partial frame is abandoned so the next start bit resynchronises.
      state_d     = IDLE;
      tmo_d       = '0;
      frame_err_d = 1'b1;
      ext_pend_d  = 1'b0;
      brk_pend_d  = 1'b0;
    end

    overflow_d = overflow_q;
    if (clr_overflow) overflow_d = 1'b0;
    if (push_q && fifo_full && !rd_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync_clk_q  <= '1;
      sync_data_q <= '1;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      start_q     <= 1'b0;
      parity_q    <= 1'b0;
      tmo_q       <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync_clk_q  <= {sync_clk_q[SYNC_STAGES-2:0], ps2_clk};
      sync_data_q <= {sync_data_q[SYNC_STAGES-2:0], ps2_data};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      start_q     <= start_d;
      parity_q    <= parity_d;
      tmo_q       <= tmo_d;
      ext_pend_q  <= ext_pend_d;
      brk_pend_q  <= brk_pend_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  ps2_event_fifo #(
    .WIDTH (PS2_EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push_q),
    .push_data_i (push_data_q),
    .pop_i       (rd_ready),
    .rd_data_o   (rd_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - scoreboard bench for ps2_rx_fifo with directed PS/2 frames
module tb_ps2_rx_fifo;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_ready = 1'b0;
  logic       clr_overflow = 1'b0;
  logic [9:0] rd_data;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_seen = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (4),
    .SYNC_STAGES    (3),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .fifo_count   (fifo_count),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      if (frame_err === 1'b1) err_seen++;
      if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pop_unexpected: got %0h expected no entry", rd_data);
        end else begin
          check("pop_data", 32'(rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  // mode 1: empty-FIFO latency, 2: error pulse timing, 3: pop exactly in the push cycle
  task automatic ps2_bit(input logic v, input int mode);
    ps2_data = v;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mode == 1 && i == 3) check("lat_not_yet", 32'(rd_valid), 32'd0);
      if (mode == 1 && i == 4) check("lat_valid", 32'(rd_valid), 32'd1);
      if (mode == 2 && i == 3) check("err_pulse", 32'(frame_err), 32'd1);
      if (mode == 2 && i == 4) check("err_one_cycle", 32'(frame_err), 32'd0);
      if (mode == 3 && i == 3) rd_ready = 1'b1;
      if (mode == 3 && i == 4) begin
        rd_ready = 1'b0;
        check("full_pushpop_count", 32'(fifo_count), 32'd4);
        check("full_pushpop_ovf", 32'(overflow), 32'd0);
      end
    end
    ps2_clk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop, input int mode);
    ps2_bit(1'b0, 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 0);
    ps2_bit((~^b) ^ bad_par, 0);
    ps2_bit(stop, mode);
  endtask

  task automatic pop_n(input int n);
    rd_ready = 1'b1;
    repeat (n) @(negedge clk);
    rd_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int hit;
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    check("rst_data", 32'(rd_data), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);

    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    check("t1_count", 32'(fifo_count), 32'd1);
    check("t1_head", 32'(rd_data), 32'h01C);
    pop_n(1);
    check("t1_drained", 32'(fifo_count), 32'd0);

    exp_q.push_back(10'h375);
    send_frame(8'hE0, 1'b0, 1'b1, 0);
    send_frame(8'hF0, 1'b0, 1'b1, 0);
    check("t2_prefix_nopush", 32'(fifo_count), 32'd0);
    send_frame(8'h75, 1'b0, 1'b1, 0);
    check("t2_count", 32'(fifo_count), 32'd1);
    pop_n(1);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    pop_n(1);
    check("t2_no_err", 32'(err_seen), 32'd0);

    send_frame(8'h1C, 1'b1, 1'b1, 2);
    check("t3_parity_nopush", 32'(fifo_count), 32'd0);
    send_frame(8'hF0, 1'b0, 1'b0, 2);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    pop_n(1);
    check("t3_err_count", 32'(err_seen), 32'd2);

    ps2_bit(1'b0, 0);
    ps2_bit(1'b0, 0);
    ps2_bit(1'b0, 0);
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    hit = 0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k == 8) ps2_clk = 1'b1;
      if (frame_err === 1'b1) begin
        hit = k;
        break;
      end
    end
    check("timeout_window", 32'(hit >= 100 && hit <= 106), 32'd1);
    repeat (10) @(negedge clk);
    check("timeout_err_once", 32'(err_seen), 32'd3);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 0);
    pop_n(1);
    check("timeout_recover_count", 32'(fifo_count), 32'd0);

    exp_q.push_back(10'h016);
    exp_q.push_back(10'h01E);
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h025);
    send_frame(8'h16, 1'b0, 1'b1, 0);
    send_frame(8'h1E, 1'b0, 1'b1, 0);
    send_frame(8'h26, 1'b0, 1'b1, 0);
    send_frame(8'h25, 1'b0, 1'b1, 0);
    check("ovf_before_drop", 32'(overflow), 32'd0);
    send_frame(8'h2E, 1'b0, 1'b1, 0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_set", 32'(overflow), 32'd1);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    pop_n(4);
    check("ovf_drained", 32'(fifo_count), 32'd0);

    exp_q.push_back(10'h016);
    exp_q.push_back(10'h01E);
    exp_q.push_back(10'h026);
    exp_q.push_back(10'h025);
    exp_q.push_back(10'h02E);
    send_frame(8'h16, 1'b0, 1'b1, 0);
    send_frame(8'h1E, 1'b0, 1'b1, 0);
    send_frame(8'h26, 1'b0, 1'b1, 0);
    send_frame(8'h25, 1'b0, 1'b1, 0);
    check("full_count", 32'(fifo_count), 32'd4);
    send_frame(8'h2E, 1'b0, 1'b1, 3);
    check("full_head_after", 32'(rd_data), 32'h01E);

    ps2_bit(1'b0, 0);
    ps2_bit(1'b1, 0);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    exp_q.delete();
    check("midrst_valid", 32'(rd_valid), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    repeat (150) @(negedge clk);
    check("midrst_no_err", 32'(err_seen), 32'd3);
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 1'b0, 1'b1, 1);
    pop_n(1);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no completion expected finish within time limit");
    $fatal(1);
  end

endmodule
